multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control FSM: the producer side of the datapath ALU interface; it decodes opcode/funct and drives
//  alu_control plus all datapath enables/selects for one shared memory port. Consumes ALU zero for beq.
//  Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, j. Sits between IR fields and the datapath muxes.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles to wait for mem_ready in FETCH/MEMRD/MEMWR before abort (1..255)
// PORTS
//  clk         in   1  clock; all state changes on rising edge
//  rst         in   1  reset, asynchronous, active-high
//  opcode      in   6  IR[31:26]
//  funct       in   6  IR[5:0]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory access completes this cycle
//  alu_control out  3  000 and,001 or,010 add,110 sub,111 slt
//  alu_src_a   out  1  0=PC, 1=regA
//  alu_src_b   out  2  00=regB, 01=4, 10=signimm, 11=signimm<<2
//  pc_src      out  2  00=ALU result, 01=ALUOut, 10=jump target
//  iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, branch, pc_write  out 1 each
//  pc_en       out  1  pc_write | (branch & zero)
//  illegal     out  1  1-cycle pulse: unknown opcode or funct
//  mem_err     out  1  1-cycle pulse: memory timeout
//  state       out  4  current state code (debug)
// BEHAVIOUR
//  Outputs are combinational from state (plus mem_ready/funct/zero where noted); unlisted outputs are 0.
//  rst asserted (any time, mid-access included): state=RST(0) immediately; all outputs 0; wait counter 0.
//  RST(0): all 0 -> FETCH.
//  FETCH(1): iord=0,a=0,b=01,alu=010. If mem_ready: ir_write=1,pc_write=1,pc_src=00 -> DECODE; else hold.
//  DECODE(2): a=0,b=11,alu=010. op 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX,
//    000010->JUMP; other: illegal=1 -> FETCH.
//  MEMADR(3): a=1,b=10,alu=010. lw->MEMRD, sw->MEMWR.
//  MEMRD(4): iord=1; wait mem_ready -> MEMWB.     MEMWB(5): reg_dst=0,mem_to_reg=1,reg_write=1 -> FETCH.
//  MEMWR(6): iord=1,mem_write=1 held until mem_ready -> FETCH.
//  EXEC(7): a=1,b=00; alu by funct: 100000->010,100010->110,100100->000,100101->001,101010->111;
//    unknown funct: alu=010 -> ALUWB. ALUWB(8): reg_dst=1,mem_to_reg=0; reg_write=1 only for known funct,
//    else reg_write=0,illegal=1 -> FETCH.
//  BRANCH(9): a=1,b=00,alu=110,branch=1,pc_src=01 -> FETCH; pc_en=zero.
//  ADDIEX(10): a=1,b=10,alu=010 -> ADDIWB(11): reg_dst=0,mem_to_reg=0,reg_write=1 -> FETCH.
//  JUMP(12): pc_src=10,pc_write=1 -> FETCH.  Codes 13-15 unreachable; if entered -> FETCH, outputs 0.
//  Wait counter (8b): cleared on entry to FETCH/MEMRD/MEMWR, +1 per cycle without mem_ready. If mem_ready
//    not seen when counter==MEM_TIMEOUT-1: mem_err=1 that cycle, no enables, -> FETCH (refetch same PC).
//  mem_ready in the timeout cycle wins: normal completion, no mem_err.
//  mem_ready outside FETCH/MEMRD/MEMWR ignored. Latency, zero wait: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
// TESTING
//  rst pulse mid-MEMRD -> state=0, all outputs 0 during rst; FETCH one cycle after release.
//  lw (op 100011), mem_ready=1 always -> states 1,2,3,4,5,1; reg_write+mem_to_reg only in MEMWB.
//  R sub (funct 100010) -> alu_control=110 in EXEC, reg_dst=1,reg_write=1 in ALUWB; funct 111111 -> illegal pulse, no reg_write.
//  beq zero=1 -> pc_en=1,pc_src=01 in BRANCH; zero=0 -> pc_en=0; j -> pc_write=1,pc_src=10.
//  sw, mem_ready low 3 cycles -> mem_write=1 held 4 cycles, single FETCH transition after ready.
//  MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> mem_err pulse on 4th cycle, ir_write never 1, FETCH restarts.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multicycle MIPS datapath with one shared memory port.
//   It decodes opcode/funct and drives the ALU operation plus every datapath
//   enable and mux select. Supported instructions: lw, sw, R-type
//   (add/sub/and/or/slt), beq, addi and j.
//
// Ports
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   opcode, funct  IR[31:26] and IR[5:0]; expected to be held stable by the IR
//   zero           ALU zero flag, used for beq
//   mem_ready      memory access completes in this cycle
//   alu_control    000 and, 001 or, 010 add, 110 sub, 111 slt
//   alu_src_a      0 = PC, 1 = regA
//   alu_src_b      00 = regB, 01 = 4, 10 = signimm, 11 = signimm<<2
//   pc_src         00 = ALU result, 01 = ALUOut, 10 = jump target
//   iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, branch,
//   pc_write       single-bit datapath controls
//   pc_en          pc_write | (branch & zero)
//   illegal        one-cycle pulse on an unknown opcode or funct
//   mem_err        one-cycle pulse when a memory access times out
//   state          current state code, for debug and checkers
//
// Memory handshake: the controller holds its request (iord/mem_write/ir_write
// intent) for as long as it sits in FETCH, MEMRD or MEMWR. A cycle with
// mem_ready=1 in one of those states completes the access and the FSM moves
// on at the next rising edge. mem_ready in any other state is ignored.
// If mem_ready has not been seen by the MEM_TIMEOUT-th cycle of a wait, that
// cycle raises mem_err, suppresses all enables and returns to FETCH (the PC
// was not written, so the same instruction is refetched). mem_ready arriving
// in that very cycle still completes normally.

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       branch,
  output logic       pc_write,
  output logic       pc_en,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur_state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       wait_state;
  logic       timeout;
  logic       funct_known;

  assign state = cur_state;

  assign wait_state = (cur_state == S_FETCH) || (cur_state == S_MEMRD) ||
                      (cur_state == S_MEMWR);
  assign timeout    = wait_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    funct_known = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_known = 1'b1;
      default:                               funct_known = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= S_RST;
    else     cur_state <= state_next;
  end

  // Wait counter: any state change or a timeout counts as a fresh entry,
  // which also covers the FETCH -> FETCH restart after a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if ((state_next != cur_state) || timeout) begin
      wait_cnt <= 8'd0;
    end else if (wait_state && !mem_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Next state and outputs
  always_comb begin
    state_next  = cur_state;
    alu_control = 3'b000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    iord        = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    branch      = 1'b0;
    pc_write    = 1'b0;
    illegal     = 1'b0;
    mem_err     = 1'b0;

    case (cur_state)
      S_RST: begin
        state_next = S_FETCH;
      end

      S_FETCH: begin
        iord        = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = 2'b00;
          state_next = S_DECODE;
        end else if (timeout) begin
          mem_err    = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_DECODE: begin
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (timeout) begin
          mem_err    = 1'b1;
          state_next = S_FETCH;
        end
      end

      S_MEMWB: begin
        reg_dst    = 1'b0;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        iord = 1'b1;
        if (mem_ready) begin
          mem_write  = 1'b1;
          state_next = S_FETCH;
        end else if (timeout) begin
          // Abort: drop the write strobe so the timed-out store has no effect.
          mem_err    = 1'b1;
          state_next = S_FETCH;
        end else begin
          mem_write = 1'b1;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst    = 1'b1;
        mem_to_reg = 1'b0;
        reg_write  = funct_known;
        illegal    = !funct_known;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b00;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_src      = 2'b01;
        state_next  = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_next  = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end

      // Codes 13-15 are unreachable; recover to FETCH with outputs idle.
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed-vector bench for multicycle_ctrl, built with MEM_TIMEOUT=4 so
//   the timeout path and the "ready on the last wait cycle" boundary are
//   both reachable in a few cycles. Inputs change 1 time unit after a rising
//   edge; outputs are sampled 1 time unit later, well away from the edge.

module tb_multicycle_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write;
  logic       branch, pc_write, pc_en, illegal, mem_err;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .iord(iord), .ir_write(ir_write),
    .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .branch(branch), .pc_write(pc_write), .pc_en(pc_en),
    .illegal(illegal), .mem_err(mem_err), .state(state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // All outputs packed into one vector so "everything is zero" is one check.
  wire [22:0] all_outs = {alu_control, alu_src_a, alu_src_b, pc_src, iord,
                          ir_write, mem_write, reg_dst, mem_to_reg, reg_write,
                          branch, pc_write, pc_en, illegal, mem_err, state};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present an instruction, complete the fetch and land in DECODE.
  task automatic fetch_go(input logic [5:0] op, input logic [5:0] fn);
    opcode    = op;
    funct     = fn;
    mem_ready = 1'b1;
    #1;
    check("fetch_state", state, 4'd1);
    check("fetch_ir_write", ir_write, 1'b1);
    check("fetch_pc_en", pc_en, 1'b1);
    check("fetch_alu", {alu_control, alu_src_b, iord}, {3'b010, 2'b01, 1'b0});
    tick();
    mem_ready = 1'b0;
    #1;
    check("decode_state", state, 4'd2);
    check("decode_srcb", alu_src_b, 2'b11);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset_all_zero", all_outs, 23'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    check("post_reset_fetch", state, 4'd1);
    check("fetch_wait_no_ir", ir_write, 1'b0);

    // lw with memory always ready: 1,2,3,4,5,1
    fetch_go(6'b100011, 6'd0);
    mem_ready = 1'b1;
    tick(); #1;
    check("lw_memadr", {state, alu_src_a, alu_src_b, reg_write},
          {4'd3, 1'b1, 2'b10, 1'b0});
    tick(); #1;
    check("lw_memrd", {state, iord, reg_write, mem_to_reg},
          {4'd4, 1'b1, 1'b0, 1'b0});
    tick(); #1;
    check("lw_memwb", {state, reg_write, mem_to_reg, reg_dst},
          {4'd5, 1'b1, 1'b1, 1'b0});
    mem_ready = 1'b0;
    tick(); #1;
    check("lw_back_fetch", {state, reg_write}, {4'd1, 1'b0});

    // Reset asserted in the middle of MEMRD
    fetch_go(6'b100011, 6'd0);
    tick(); tick(); #1;
    check("rst_pre_memrd", state, 4'd4);
    rst = 1'b1;
    #1;
    check("rst_async_zero", all_outs, 23'd0);
    tick();
    check("rst_held_zero", all_outs, 23'd0);
    rst = 1'b0;
    tick(); #1;
    check("rst_release_fetch", state, 4'd1);

    // R-type sub
    fetch_go(6'b000000, 6'b100010);
    tick(); #1;
    check("sub_exec", {state, alu_control, alu_src_a, alu_src_b},
          {4'd7, 3'b110, 1'b1, 2'b00});
    tick(); #1;
    check("sub_aluwb", {state, reg_dst, reg_write, illegal, mem_to_reg},
          {4'd8, 1'b1, 1'b1, 1'b0, 1'b0});
    tick(); #1;
    check("sub_back_fetch", state, 4'd1);

    // R-type slt and or, checked in EXEC only
    fetch_go(6'b000000, 6'b101010);
    tick(); #1;
    check("slt_exec_alu", alu_control, 3'b111);
    tick(); tick(); #1;
    fetch_go(6'b000000, 6'b100101);
    tick(); #1;
    check("or_exec_alu", alu_control, 3'b001);
    tick(); tick(); #1;

    // R-type with unknown funct
    fetch_go(6'b000000, 6'b111111);
    tick(); #1;
    check("badfn_exec_alu", alu_control, 3'b010);
    tick(); #1;
    check("badfn_aluwb", {state, reg_write, illegal}, {4'd8, 1'b0, 1'b1});
    tick(); #1;
    check("badfn_pulse_end", {state, illegal}, {4'd1, 1'b0});

    // Unknown opcode: illegal in DECODE, straight back to FETCH
    opcode = 6'b111111;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    check("badop_decode", {state, illegal}, {4'd2, 1'b1});
    tick(); #1;
    check("badop_fetch", {state, illegal}, {4'd1, 1'b0});

    // beq taken and not taken
    fetch_go(6'b000100, 6'd0);
    zero = 1'b1;
    tick(); #1;
    check("beq_taken", {state, pc_en, pc_src, branch, alu_control},
          {4'd9, 1'b1, 2'b01, 1'b1, 3'b110});
    zero = 1'b0;
    #1;
    check("beq_not_taken", {pc_en, pc_write}, {1'b0, 1'b0});
    tick(); #1;
    check("beq_back_fetch", state, 4'd1);

    // j
    fetch_go(6'b000010, 6'd0);
    tick(); #1;
    check("jump", {state, pc_write, pc_src, pc_en}, {4'd12, 1'b1, 2'b10, 1'b1});
    tick(); #1;
    check("jump_back_fetch", state, 4'd1);

    // addi
    fetch_go(6'b001000, 6'd0);
    tick(); #1;
    check("addi_ex", {state, alu_src_a, alu_src_b, alu_control, reg_write},
          {4'd10, 1'b1, 2'b10, 3'b010, 1'b0});
    tick(); #1;
    check("addi_wb", {state, reg_write, reg_dst, mem_to_reg},
          {4'd11, 1'b1, 1'b0, 1'b0});
    tick(); #1;
    check("addi_back_fetch", state, 4'd1);

    // sw with memory ready only on the 4th MEMWR cycle (last before timeout)
    fetch_go(6'b101011, 6'd0);
    tick(); #1;
    check("sw_memadr", state, 4'd3);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("sw_wait_hold", {state, mem_write, iord, mem_err},
            {4'd6, 1'b1, 1'b1, 1'b0});
    end
    tick();
    mem_ready = 1'b1;
    #1;
    check("sw_ready_last", {state, mem_write, mem_err}, {4'd6, 1'b1, 1'b0});
    tick();
    mem_ready = 1'b0;
    #1;
    check("sw_single_fetch", {state, mem_write}, {4'd1, 1'b0});

    // Timeout in FETCH: entered FETCH above, mem_ready stuck low
    for (int i = 0; i < TMO - 1; i++) begin
      check("fetch_wait_no_err", {state, mem_err, ir_write}, {4'd1, 1'b0, 1'b0});
      tick(); #1;
    end
    check("fetch_timeout", {state, mem_err, ir_write, pc_en},
          {4'd1, 1'b1, 1'b0, 1'b0});
    tick(); #1;
    check("fetch_restart", {state, mem_err}, {4'd1, 1'b0});
    tick(); #1;
    check("fetch_restart_cnt", mem_err, 1'b0);

    // Timeout in MEMRD after a fresh fetch
    fetch_go(6'b100011, 6'd0);
    tick(); tick(); #1;
    for (int i = 0; i < TMO - 1; i++) begin
      check("memrd_wait", {state, mem_err}, {4'd4, 1'b0});
      tick(); #1;
    end
    check("memrd_timeout", {state, mem_err, reg_write}, {4'd4, 1'b1, 1'b0});
    tick(); #1;
    check("memrd_abort_fetch", {state, mem_err}, {4'd1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
